// File: rtl/clk_monitor.sv
// Slow external clock monitor: synchronizes an asynchronous clock, emits edge strobes,
// measures high/low phase lengths in i_clk cycles and flags a stopped clock.
module clk_monitor #(
  parameter int unsigned           CNT_WIDTH   = 12,
  parameter logic [CNT_WIDTH-1:0]  STALL_COUNT = 12'd4000
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  input  logic                 i_start_stb,
  input  logic                 i_reset_stb,
  input  logic                 i_ext_clk,
  output logic                 o_ext_clk,
  output logic                 o_rose,
  output logic                 o_fell,
  output logic [CNT_WIDTH-1:0] o_high_count,
  output logic [CNT_WIDTH-1:0] o_low_count,
  output logic                 o_period_valid,
  output logic                 o_stalled
);

  // state     | meaning
  // IDLE      | not monitoring, strobes suppressed
  // ARMING    | waiting for the first rising edge
  // MEASURING | timing high/low phases
  // STALLED   | no edge for STALL_COUNT cycles, waiting for a rise
  typedef enum logic [1:0] {IDLE, ARMING, MEASURING, STALLED} state_t;

  localparam logic [CNT_WIDTH-1:0] STALL_LAST = STALL_COUNT - 1'b1;

  state_t               state;
  logic                 s1, s2, s3;
  logic                 ext_rise, ext_fall;
  logic                 high_seen;
  logic [CNT_WIDTH-1:0] cnt;

  assign ext_rise  = s2 & ~s3;
  assign ext_fall  = ~s2 & s3;
  assign o_ext_clk = s2;

  always_ff @(posedge i_clk) begin
    if (!i_reset_n) begin
      state          <= IDLE;
      s1             <= 1'b0;
      s2             <= 1'b0;
      s3             <= 1'b0;
      cnt            <= '0;
      high_seen      <= 1'b0;
      o_rose         <= 1'b0;
      o_fell         <= 1'b0;
      o_high_count   <= '0;
      o_low_count    <= '0;
      o_period_valid <= 1'b0;
      o_stalled      <= 1'b0;
    end else begin
      s1     <= i_ext_clk;
      s2     <= s1;
      s3     <= s2;
      o_rose <= 1'b0;
      o_fell <= 1'b0;
      if (state != IDLE && i_reset_stb) begin
        state          <= IDLE;
        cnt            <= '0;
        high_seen      <= 1'b0;
        o_high_count   <= '0;
        o_low_count    <= '0;
        o_period_valid <= 1'b0;
        o_stalled      <= 1'b0;
      end else begin
        if (state != IDLE) begin
          o_rose <= ext_rise;
          o_fell <= ext_fall;
        end
        case (state)
          IDLE: begin
            if (i_start_stb && !i_reset_stb) begin
              state <= ARMING;
              cnt   <= '0;
            end
          end
          ARMING: begin
            if (ext_rise) begin
              state          <= MEASURING;
              cnt            <= '0;
              high_seen      <= 1'b0;
              o_stalled      <= 1'b0;
              o_period_valid <= 1'b0;
            end else if (ext_fall) begin
              // any edge proves the clock is alive, so restart the stall timer
              cnt <= '0;
            end else if (cnt == STALL_LAST) begin
              state          <= STALLED;
              o_stalled      <= 1'b1;
              o_period_valid <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          MEASURING: begin
            if (ext_fall) begin
              o_high_count <= cnt + 1'b1;
              cnt          <= '0;
              high_seen    <= 1'b1;
            end else if (ext_rise) begin
              o_low_count <= cnt + 1'b1;
              cnt         <= '0;
              if (high_seen) o_period_valid <= 1'b1;
            end else if (cnt == STALL_LAST) begin
              state          <= STALLED;
              o_stalled      <= 1'b1;
              o_period_valid <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          STALLED: begin
            if (ext_rise) begin
              state          <= MEASURING;
              cnt            <= '0;
              high_seen      <= 1'b0;
              o_stalled      <= 1'b0;
              o_period_valid <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: doc/clk_monitor.md
# clk_monitor

Receive-side companion to the clock divider. Samples a slow external clock (divided system clock, Z80 CLK, or any off-board clock) in the `i_clk` domain. Produces a synchronized copy, one-cycle rise/fall strobes, and measured high/low phase lengths in `i_clk` cycles. Flags a stopped clock. Bring-up logic and the bus sequencer use it to check and follow the Z80 clock.

## Interface
Parameters:
- `CNT_WIDTH`, default 12: width of the phase counter and the measurement outputs.
- `STALL_COUNT`, default 12'd4000: number of cycles without an edge before `o_stalled` asserts. Must satisfy 2 ≤ `STALL_COUNT` < 2^`CNT_WIDTH`.

Ports:
- `i_clk`, in, 1: system clock. The only clock in the block.
- `i_reset_n`, in, 1: synchronous, active-low reset.
- `i_start_stb`, in, 1: one-cycle strobe that arms monitoring. Acts only in IDLE.
- `i_reset_stb`, in, 1: one-cycle strobe that returns the block to IDLE and clears results.
- `i_ext_clk`, in, 1: asynchronous external clock.
- `o_ext_clk`, out, 1: synchronized external clock. Always valid, including in IDLE.
- `o_rose`, out, 1: one-cycle strobe on a synchronized rising edge. Never asserts in IDLE.
- `o_fell`, out, 1: one-cycle strobe on a synchronized falling edge. Never asserts in IDLE.
- `o_high_count`, out, CNT_WIDTH: length of the last completed high phase, in `i_clk` cycles.
- `o_low_count`, out, CNT_WIDTH: length of the last completed low phase, in `i_clk` cycles.
- `o_period_valid`, out, 1: both counts describe phases captured since the last (re)sync.
- `o_stalled`, out, 1: no edge seen for `STALL_COUNT` cycles.

## Operation
- **Synchronizer:** a chain of two flops, s1 and s2, followed by a history flop s3. `o_ext_clk` = s2.
  - Internal rise = s2 & ~s3. Internal fall = ~s2 & s3.
  - These run in every state. s1, s2 and s3 are all reset to 0.
- **States:** IDLE, ARMING, MEASURING, STALLED.
- **Transitions, highest priority first:**
  1. `!i_reset_n`: go to IDLE.
  2. `i_reset_stb` in any non-IDLE state: go to IDLE. All outputs except `o_ext_clk` are cleared, and `cnt` is set to 0.
  3. IDLE with `i_start_stb` and no `i_reset_stb`: go to ARMING with `cnt` = 0. If start and reset strobes arrive together in IDLE, the block stays in IDLE.
  4. ARMING or STALLED with an internal rise: go to MEASURING with `cnt` = 0. `o_stalled` clears and `o_period_valid` clears.
  5. ARMING or MEASURING with no internal edge and `cnt` == `STALL_COUNT`-1: go to STALLED. `o_stalled` = 1, `o_period_valid` = 0, and the count registers hold.
  6. `i_start_stb` outside IDLE is ignored.
- **Counter (MEASURING):**
  - On an internal fall: `o_high_count` ← `cnt`+1, and `cnt` ← 0.
  - On an internal rise: `o_low_count` ← `cnt`+1, and `cnt` ← 0. If a high phase has been captured since entering MEASURING, set `o_period_valid` = 1.
  - With no edge: `cnt` ← `cnt`+1.
  - `cnt` never wraps, because the stall rule fires first.
- **ARMING:** counts toward the stall threshold. No counts are captured and no fall strobe is needed.
- **STALLED:** `cnt` holds. Only an internal rise or a reset leaves this state. Falls are reported on `o_fell` but start nothing.
- **Reset values:** all outputs are 0. State = IDLE, `cnt` = 0.

## Timing
- Input-to-strobe latency: if `i_ext_clk` changes and is first sampled into s1 at edge k, s2 changes at k+1. The internal edge is then true during cycle k+1..k+2, and `o_rose`/`o_fell` are high for exactly the cycle following edge k+2.
- `o_high_count`, `o_low_count` and `o_period_valid` update on the same edge that raises the matching strobe.
- `o_stalled` rises on the edge at which `cnt` would reach `STALL_COUNT`.
- The state change on `i_reset_stb` or `i_start_stb` takes effect at the next edge. An internal edge in that same cycle is ignored.
- Pulses shorter than 1 `i_clk` cycle may be missed. This is allowed. The input is assumed glitch-free.
- Measured counts equal the true phase length, ±1 cycle of sampling jitter.

## Test plan
- **Locked divider:** drive `i_ext_clk` from a divider toggling every 10 cycles, then pulse start. Required: the first `o_rose` occurs without valid. After the next fall and rise, `o_high_count` = `o_low_count` = 10 and `o_period_valid` = 1. Each strobe lasts exactly 1 cycle.
- **Asymmetric clock:** high 7 cycles, low 13 cycles. Required: `o_high_count` = 7, `o_low_count` = 13, stable over 5 periods.
- **Stall and recover:** with `STALL_COUNT` = 50, hold `i_ext_clk` at 0 after a fall. Required: `o_stalled` = 1 and `o_period_valid` = 0 exactly 50 cycles after the last edge. The next rise clears `o_stalled`, and valid returns only after a further fall and rise.
- **Strobe handling:** send start while in MEASURING, and start together with reset while in IDLE. Required: the start is ignored and the block stays IDLE. A reset strobe mid-high-phase returns to IDLE with all outputs 0 except `o_ext_clk`, and no further `o_rose` appears.
- **Latency and reset:** step `i_ext_clk` from 0 to 1 just before edge k. Required: `o_rose` is high only in the cycle after edge k+2. Pulling `i_reset_n` low for 1 cycle mid-measurement zeroes every output at that edge.
